// File: rtl/txn_sink.sv
// txn_sink: terminal responder for the dut_if chain.
// Buffers accepted cmd/adr/data beats in a show-ahead FIFO, keeps per-address
// data-value coverage bitmaps, and counts accepted and dropped beats.
module txn_sink #(
    parameter int unsigned ADR_W  = 2,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd,
    input  logic [ADR_W-1:0]           adr,
    input  logic [DATA_W-1:0]          data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [ADR_W-1:0]           rd_adr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clr_cov,
    input  logic [ADR_W-1:0]           cov_sel,
    output logic [(2**DATA_W)-1:0]     cov_map,
    output logic                       cov_full,
    output logic [CNT_W-1:0]           txn_count,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned EW   = ADR_W + DATA_W;
    localparam int unsigned NMAP = 2**ADR_W;
    localparam int unsigned MAPW = 2**DATA_W;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic [CNT_W-1:0] txn_q;
    logic [CNT_W-1:0] drop_q;
    logic [MAPW-1:0]  cov_q [NMAP];

    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [EW-1:0]    head;

    // Handshake decode: a pop frees a slot for a same-cycle push even at full.
    always_comb begin
        pop  = 1'b0;
        full = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = rd_en && (count_q != '0);
        full = (count_q == CW'(DEPTH));
        push = cmd && (!full || pop);
        drop = cmd && full && !pop;
    end

    // FIFO storage; written only on an accepted beat outside reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= {adr, data};
        end
    end

    // Pointers, occupancy, sticky overflow and saturating beat counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            txn_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (txn_q != {CNT_W{1'b1}}) begin
                    txn_q <= txn_q + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != {CNT_W{1'b1}}) begin
                    drop_q <= drop_q + CNT_W'(1);
                end
            end
        end
    end

    // Coverage maps: clear first, then the same-cycle beat sets its bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NMAP); i++) begin
                cov_q[i] <= '0;
            end
        end else begin
            if (clr_cov) begin
                for (int i = 0; i < int'(NMAP); i++) begin
                    cov_q[i] <= '0;
                end
            end
            if (cmd) begin
                cov_q[adr][data] <= 1'b1;
            end
        end
    end

    // Show-ahead head and status; head forced to zero while empty so
    // uninitialised storage never reaches the outputs.
    always_comb begin
        head       = '0;
        rd_valid   = (count_q != '0);
        if (rd_valid) begin
            head = mem[rd_ptr_q];
        end
        rd_adr     = head[EW-1:DATA_W];
        rd_data    = head[DATA_W-1:0];
        fifo_count = count_q;
        overflow   = ovf_q;
        txn_count  = txn_q;
        drop_count = drop_q;
        cov_map    = cov_q[cov_sel];
        cov_full   = &cov_q[cov_sel];
    end

endmodule

// File: tb/tb_txn_sink.sv
// Directed/random bench for txn_sink with a reference queue and coverage model.
module tb_txn_sink;

    logic        clk;
    logic        rst_n;
    logic        cmd;
    logic [1:0]  adr;
    logic [2:0]  data;
    logic        rd_en;
    logic        rd_valid;
    logic [1:0]  rd_adr;
    logic [2:0]  rd_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        clr_cov;
    logic [1:0]  cov_sel;
    logic [7:0]  cov_map;
    logic        cov_full;
    logic [15:0] txn_count;
    logic [15:0] drop_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    logic [4:0] q[$];
    int         m_txn;
    int         m_drop;
    bit         m_ovf;
    logic [7:0] m_map [4];

    txn_sink #(.ADR_W(2), .DATA_W(3), .DEPTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .adr        (adr),
        .data       (data),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_adr     (rd_adr),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_cov    (clr_cov),
        .cov_sel    (cov_sel),
        .cov_map    (cov_map),
        .cov_full   (cov_full),
        .txn_count  (txn_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the reference model.
    task automatic check_state();
        chk("fifo_count", 32'(fifo_count), q.size());
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_adr", 32'(rd_adr), 32'(q[0][4:3]));
            chk("head_data", 32'(rd_data), 32'(q[0][2:0]));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("txn_count", 32'(txn_count), m_txn);
        chk("drop_count", 32'(drop_count), m_drop);
        chk("cov_map", 32'(cov_map), 32'(m_map[cov_sel]));
        chk("cov_full", 32'(cov_full), 32'(m_map[cov_sel] == 8'hFF));
    endtask

    // Predict the edge from current inputs, pop/compare scoreboard, advance one clock.
    task automatic cycle();
        logic [4:0] e;
        int         sz;
        bit         pop;
        if (!rst_n) begin
            q.delete();
            m_txn  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
            foreach (m_map[i]) m_map[i] = 8'h00;
        end else begin
            sz  = q.size();
            pop = rd_en && (sz != 0);
            if (pop) begin
                e = q.pop_front();
                chk("pop_valid", 32'(rd_valid), 32'd1);
                chk("pop_adr", 32'(rd_adr), 32'(e[4:3]));
                chk("pop_data", 32'(rd_data), 32'(e[2:0]));
            end
            if (cmd) begin
                if (sz < 8 || pop) begin
                    q.push_back({adr, data});
                    if (m_txn < 65535) m_txn++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            if (clr_cov) foreach (m_map[i]) m_map[i] = 8'h00;
            if (cmd) m_map[adr][data] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic drive(input bit c, input logic [1:0] a, input logic [2:0] d, input bit r);
        cmd   = c;
        adr   = c ? a : 2'bxx;
        data  = c ? d : 3'bxxx;
        rd_en = r;
        cycle();
    endtask

    initial begin
        rst_n   = 1'b0;
        cmd     = 1'b0;
        adr     = '0;
        data    = '0;
        rd_en   = 1'b0;
        clr_cov = 1'b0;
        cov_sel = 2'd0;
        #1;
        cycle();
        cycle();
        chk("rst_rd_adr", 32'(rd_adr), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // Single beat into empty FIFO
        cov_sel = 2'd1;
        drive(1, 2'd1, 3'd5, 0);
        chk("t1_cov_map", 32'(cov_map), 32'h20);
        chk("t1_rd_data", 32'(rd_data), 32'd5);
        drive(0, 0, 0, 1);

        // Nine beats with no reader: eighth fills, ninth drops; then drain
        for (int i = 0; i < 9; i++) drive(1, 2'(i % 4), 3'(i), 0);
        chk("t2_drop", 32'(drop_count), 32'd1);
        chk("t2_full", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);
        chk("t2_empty", 32'(rd_valid), 32'd0);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together at full
        for (int i = 0; i < 8; i++) drive(1, 2'd3, 3'(7 - i), 0);
        drive(1, 2'd0, 3'd6, 1);
        chk("t3_count", 32'(fifo_count), 32'd8);
        chk("t3_nodrop", 32'(drop_count), 32'd1);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);

        // Full coverage of address 2, then clear with a same-cycle beat
        cov_sel = 2'd2;
        for (int i = 0; i < 8; i++) drive(1, 2'd2, 3'(i), 1);
        chk("t4_map_ff", 32'(cov_map), 32'hFF);
        chk("t4_full", 32'(cov_full), 32'd1);
        clr_cov = 1'b1;
        drive(1, 2'd2, 3'd3, 1);
        clr_cov = 1'b0;
        chk("t4_map_08", 32'(cov_map), 32'h08);
        chk("t4_notfull", 32'(cov_full), 32'd0);

        // Random traffic, then reset mid-burst
        for (int i = 0; i < 100; i++) begin
            cov_sel = 2'($urandom_range(1, 2));
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(1, 2)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        rst_n = 1'b0;
        drive(1, 2'd1, 3'd2, 1);
        rst_n = 1'b1;
        chk("t5_count", 32'(fifo_count), 32'd0);
        chk("t5_txn", 32'(txn_count), 32'd0);
        chk("t5_cov", 32'(cov_map), 32'd0);
        chk("t5_rd_adr", 32'(rd_adr), 32'd0);
        chk("t5_rd_data", 32'(rd_data), 32'd0);
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
